// File: rtl/kl8_pkg.sv
// Shared constants and types for the KL8 console teletype controller:
// IOP bit masks, the serial FSM state encoding and the bit-period helper.
package kl8_pkg;

  localparam logic [2:0] IOP1 = 3'b001;
  localparam logic [2:0] IOP2 = 3'b010;
  localparam logic [2:0] IOP4 = 3'b100;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  // Clock cycles per serial bit (integer floor).
  function automatic int unsigned bit_div(input int unsigned clk_freq,
                                          input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/kl8_tty_if.sv
// CPU-side IOT bus of the KL8 teletype controller: request fields from the CPU,
// registered response and interrupt request back to it.
interface kl8_tty_if;
  logic       iot_valid;
  logic [5:0] iot_dev;
  logic [2:0] iot_op;
  logic [7:0] ac_in;
  logic       iot_done;
  logic       skip;
  logic       ac_clear;
  logic [7:0] ac_or;
  logic       int_req;

  modport master (
    output iot_valid, iot_dev, iot_op, ac_in,
    input  iot_done, skip, ac_clear, ac_or, int_req
  );

  modport slave (
    input  iot_valid, iot_dev, iot_op, ac_in,
    output iot_done, skip, ac_clear, ac_or, int_req
  );
endinterface

// File: rtl/kl8_tx_shifter.sv
// 8N1 serial transmitter for the printer side, with a one-deep pending byte.
// state     | meaning
// SER_IDLE  | line high, waiting for a load
// SER_START | driving the start bit
// SER_DATA  | shifting out 8 data bits, LSB first
// SER_STOP  | driving the stop bit; done pulses on its last cycle
module kl8_tx_shifter
  import kl8_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       tx_data,
  output logic       done
);

  localparam int CNT_W = $clog2(DIV);

  ser_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shift;
  logic [2:0]       idx;
  logic             pend_valid;
  logic [7:0]       pend_data;
  logic             tick;

  assign tick = (cnt == '0);
  assign done = (state == SER_STOP) && tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SER_IDLE;
      cnt        <= '0;
      shift      <= 8'h00;
      idx        <= 3'd0;
      pend_valid <= 1'b0;
      pend_data  <= 8'h00;
      tx_data    <= 1'b1;
    end else begin
      // A load while busy always lands in pending; the STOP branch below may
      // consume it in the same cycle.
      if (load && (state != SER_IDLE)) begin
        pend_valid <= 1'b1;
        pend_data  <= load_data;
      end
      case (state)
        SER_IDLE: begin
          tx_data <= 1'b1;
          if (load) begin
            shift   <= load_data;
            cnt     <= CNT_W'(DIV - 1);
            state   <= SER_START;
            tx_data <= 1'b0;
          end
        end
        SER_START: begin
          if (tick) begin
            cnt     <= CNT_W'(DIV - 1);
            idx     <= 3'd0;
            state   <= SER_DATA;
            tx_data <= shift[0];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SER_DATA: begin
          if (tick) begin
            cnt   <= CNT_W'(DIV - 1);
            shift <= {1'b0, shift[7:1]};
            if (idx == 3'd7) begin
              state   <= SER_STOP;
              tx_data <= 1'b1;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= shift[1];
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SER_STOP: begin
          if (tick) begin
            if (pend_valid) begin
              shift   <= pend_data;
              cnt     <= CNT_W'(DIV - 1);
              state   <= SER_START;
              tx_data <= 1'b0;
              if (!load) pend_valid <= 1'b0;
            end else if (load) begin
              shift      <= load_data;
              cnt        <= CNT_W'(DIV - 1);
              state      <= SER_START;
              tx_data    <= 1'b0;
              pend_valid <= 1'b0;
            end else begin
              state <= SER_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/kl8_tty.sv
// KL8-style console teletype: keyboard receiver and printer transmitter behind
// PDP-8 IOT decode. Define KL8_RX_FIFO_EN for a 4-entry keyboard FIFO.
// state     | meaning (receive FSM)
// SER_IDLE  | waiting for a falling edge on the synchronised line
// SER_START | half-bit wait, then start-bit re-check
// SER_DATA  | sampling 8 data bits, LSB first
// SER_STOP  | sampling the stop bit; deliver or flag a framing error
module kl8_tty
  import kl8_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 230_400,
  parameter logic [5:0]  KBD_DEV   = 6'o03,
  parameter logic [5:0]  PRT_DEV   = 6'o04
) (
  input  logic       clk,
  input  logic       rst,
  kl8_tty_if.slave   bus,
  input  logic       rx_data,
  output logic       tx_data,
  output logic       rx_frame_err
);

  localparam int unsigned DIV   = bit_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF  = DIV / 2;
  localparam int          CNT_W = $clog2(DIV);

  logic             rx_s1, rx_s2, rx_prev;
  ser_state_e       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             rx_tick, rx_ok, rx_bad;

  logic kbd_hit, prt_hit;
  logic ksf, kcc, krs, tsf, tcf, tpc;
  logic kbd_flag, prt_flag, rx_err_set, tx_done;
  logic [7:0] kbd_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_data;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_tick = (rx_cnt == '0);
  assign rx_ok   = (rx_state == SER_STOP) && rx_tick && rx_s2;
  assign rx_bad  = (rx_state == SER_STOP) && rx_tick && !rx_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= SER_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      case (rx_state)
        SER_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= CNT_W'(HALF - 1);
            rx_state <= SER_START;
          end
        end
        SER_START: begin
          if (rx_tick) begin
            if (rx_s2) begin
              rx_state <= SER_IDLE;
            end else begin
              rx_cnt   <= CNT_W'(DIV - 1);
              rx_idx   <= 3'd0;
              rx_state <= SER_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        SER_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= CNT_W'(DIV - 1);
            if (rx_idx == 3'd7) rx_state <= SER_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        SER_STOP: begin
          if (rx_tick) rx_state <= SER_IDLE;
          else         rx_cnt   <= rx_cnt - CNT_W'(1);
        end
        default: rx_state <= SER_IDLE;
      endcase
    end
  end

  assign kbd_hit = bus.iot_valid && (bus.iot_dev == KBD_DEV);
  assign prt_hit = bus.iot_valid && (bus.iot_dev == PRT_DEV);
  assign ksf = kbd_hit && |(bus.iot_op & IOP1);
  assign kcc = kbd_hit && |(bus.iot_op & IOP2);
  assign krs = kbd_hit && |(bus.iot_op & IOP4);
  assign tsf = prt_hit && |(bus.iot_op & IOP1);
  assign tcf = prt_hit && |(bus.iot_op & IOP2);
  assign tpc = prt_hit && |(bus.iot_op & IOP4);

`ifdef KL8_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_full, push, pop;

  assign fifo_full = (fifo_cnt == 3'd4);
  assign push      = rx_ok && !fifo_full;
  assign pop       = kcc && (fifo_cnt != 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rx_shift;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign kbd_flag   = (fifo_cnt != 3'd0);
  assign kbd_head   = fifo_mem[rd_ptr];
  assign rx_err_set = rx_bad || (rx_ok && fifo_full);
`else
  logic [7:0] kbd_buf;
  logic       kbd_flag_q;

  // Overrun is silent: a new byte replaces an unread one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbd_buf    <= 8'h00;
      kbd_flag_q <= 1'b0;
    end else begin
      if (rx_ok) kbd_buf <= rx_shift;
      if (rx_ok)    kbd_flag_q <= 1'b1;
      else if (kcc) kbd_flag_q <= 1'b0;
    end
  end

  assign kbd_flag   = kbd_flag_q;
  assign kbd_head   = kbd_buf;
  assign rx_err_set = rx_bad;
`endif

  kl8_tx_shifter #(
    .DIV (DIV)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tpc),
    .load_data (bus.ac_in),
    .tx_data   (tx_data),
    .done      (tx_done)
  );

  // Flag sets take priority over same-cycle IOT clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prt_flag     <= 1'b0;
      rx_frame_err <= 1'b0;
      bus.iot_done <= 1'b0;
      bus.skip     <= 1'b0;
      bus.ac_clear <= 1'b0;
      bus.ac_or    <= 8'h00;
    end else begin
      if (tx_done)  prt_flag <= 1'b1;
      else if (tcf) prt_flag <= 1'b0;
      if (rx_err_set) rx_frame_err <= 1'b1;
      else if (kcc)   rx_frame_err <= 1'b0;
      bus.iot_done <= kbd_hit || prt_hit;
      bus.skip     <= (ksf && kbd_flag) || (tsf && prt_flag);
      bus.ac_clear <= kcc;
      bus.ac_or    <= krs ? kbd_head : 8'h00;
    end
  end

  assign bus.int_req = kbd_flag | prt_flag;

endmodule

// File: tb/tb_kl8_tty.sv
// Directed self-checking bench for kl8_tty: IOT responses, serial receive and
// transmit framing, pending-byte chaining, framing errors and keyboard overrun.
module tb_kl8_tty;

  localparam int unsigned CLK_F = 32_000_000;
  localparam int unsigned BAUD  = 1_000_000;
  localparam int unsigned DIV   = CLK_F / BAUD;
  localparam logic [5:0]  KBD   = 6'o03;
  localparam logic [5:0]  PRT   = 6'o04;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_data = 1'b1;
  logic tx_data;
  logic rx_frame_err;

  kl8_tty_if bus ();

  kl8_tty #(
    .CLK_FREQ  (CLK_F),
    .BAUD_RATE (BAUD),
    .KBD_DEV   (KBD),
    .PRT_DEV   (PRT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;
  logic       r_done, r_skip, r_clr;
  logic [7:0] r_or;
  int unsigned k_edge;
  int unsigned base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One IOT: strobe for one cycle, capture the response one cycle later.
  task automatic iot(input logic [5:0] dev, input logic [2:0] op, input logic [7:0] ac);
    @(negedge clk);
    bus.iot_valid = 1'b1;
    bus.iot_dev   = dev;
    bus.iot_op    = op;
    bus.ac_in     = ac;
    @(negedge clk);
    r_done = bus.iot_done;
    r_skip = bus.skip;
    r_clr  = bus.ac_clear;
    r_or   = bus.ac_or;
    k_edge = cyc;
    bus.iot_valid = 1'b0;
    bus.iot_dev   = 6'o00;
    bus.iot_op    = 3'b000;
  endtask

  task automatic wait_to(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_data = fr[i];
      repeat (DIV - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Sample the line at the centre of each of the 10 bits of a frame that
  // started right after cycle count t0.
  task automatic check_frame(input int unsigned t0, input logic [7:0] b, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      wait_to(t0 + i * DIV + DIV / 2);
      chk($sformatf("%s_bit%0d", tag, i), tx_data, fr[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iot_valid = 1'b0;
    bus.iot_dev   = 6'o00;
    bus.iot_op    = 3'b000;
    bus.ac_in     = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx_data, 1'b1);
    chk("rst_int", bus.int_req, 1'b0);
    chk("rst_done", bus.iot_done, 1'b0);
    chk("rst_or", bus.ac_or, 8'h00);
    chk("rst_err", rx_frame_err, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // reset in the middle of a transmit frame
    iot(PRT, 3'b110, 8'h55);
    chk("tls55_done", r_done, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", bus.iot_done, 1'b0);
    repeat (3 * DIV + 3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midtx_rst_tx", tx_data, 1'b1);
    chk("midtx_rst_int", bus.int_req, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    iot(PRT, 3'b001, 8'h00);
    chk("tsf_after_rst_done", r_done, 1'b1);
    chk("tsf_after_rst_skip", r_skip, 1'b0);
    for (int i = 0; i < 11; i++) begin
      repeat (DIV) @(negedge clk);
      chk($sformatf("aborted_tx_idle%0d", i), tx_data, 1'b1);
    end
    chk("aborted_tx_noflag", bus.int_req, 1'b0);

    // unaddressed device
    iot(6'o05, 3'b111, 8'hFF);
    chk("unaddr_done", r_done, 1'b0);
    chk("unaddr_skip", r_skip, 1'b0);
    chk("unaddr_clr", r_clr, 1'b0);
    chk("unaddr_or", r_or, 8'h00);

    // receive 0x41
    iot(KBD, 3'b001, 8'h00);
    chk("ksf_empty_done", r_done, 1'b1);
    chk("ksf_empty_skip", r_skip, 1'b0);
    send(8'h41, 1'b1);
    chk("rx41_int", bus.int_req, 1'b1);
    chk("rx41_err", rx_frame_err, 1'b0);
    iot(KBD, 3'b001, 8'h00);
    chk("ksf_full_skip", r_skip, 1'b1);
    iot(KBD, 3'b110, 8'h00);
    chk("krb41_done", r_done, 1'b1);
    chk("krb41_clr", r_clr, 1'b1);
    chk("krb41_or", r_or, 8'h41);
    chk("krb41_flag_clr", bus.int_req, 1'b0);

    // transmit 0x5A
    iot(PRT, 3'b110, 8'h5A);
    base = k_edge;
    chk("tls5a_clr", r_clr, 1'b0);
    chk("tls5a_or", r_or, 8'h00);
    check_frame(base, 8'h5A, "tx5a");
    wait_to(base + 10 * DIV - 1);
    chk("tx5a_flag_early", bus.int_req, 1'b0);
    wait_to(base + 10 * DIV);
    chk("tx5a_flag_set", bus.int_req, 1'b1);
    iot(PRT, 3'b001, 8'h00);
    chk("tsf5a_skip", r_skip, 1'b1);
    iot(PRT, 3'b010, 8'h00);
    chk("tcf_clears", bus.int_req, 1'b0);

    // back-to-back frames through the pending register
    iot(PRT, 3'b110, 8'h31);
    base = k_edge;
    iot(PRT, 3'b100, 8'h32);
    check_frame(base, 8'h31, "bb31");
    check_frame(base + 10 * DIV, 8'h32, "bb32");
    wait_to(base + 20 * DIV + 2);
    chk("bb_flag", bus.int_req, 1'b1);
    chk("bb_idle", tx_data, 1'b1);
    iot(PRT, 3'b010, 8'h00);

    // stop bit held low
    send(8'h7F, 1'b0);
    chk("ferr_set", rx_frame_err, 1'b1);
    chk("ferr_noflag", bus.int_req, 1'b0);
    iot(KBD, 3'b010, 8'h00);
    chk("kcc_clr", r_clr, 1'b1);
    chk("kcc_ferr_clr", rx_frame_err, 1'b0);

    // five bytes into the keyboard
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b1);
`ifdef KL8_RX_FIFO_EN
    chk("fifo_overrun_err", rx_frame_err, 1'b1);
    chk("fifo_flag", bus.int_req, 1'b1);
    for (int b = 1; b <= 4; b++) begin
      iot(KBD, 3'b110, 8'h00);
      chk($sformatf("fifo_krb%0d", b), r_or, 32'(b));
    end
    chk("fifo_empty", bus.int_req, 1'b0);
    chk("fifo_err_cleared", rx_frame_err, 1'b0);
`else
    chk("overrun_silent", rx_frame_err, 1'b0);
    iot(KBD, 3'b100, 8'h00);
    chk("krs_last", r_or, 8'h05);
    chk("krs_no_clr", r_clr, 1'b0);
    chk("krs_flag_kept", bus.int_req, 1'b1);
    iot(KBD, 3'b010, 8'h00);
    chk("kcc_flag_clr", bus.int_req, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kl8_tty.md
Name: kl8_tty

Overview:
- PDP-8/I-side console teletype controller (KL8-style): keyboard device 03, printer device 04.
- Answers CPU IOT instructions on one side and drives/receives the 8N1 serial line on the other.
- It is the far end of the host uart_tx/uart_rx link. Keyboard = serial receiver into the AC; printer = serial transmitter from the AC.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz.
- BAUD_RATE, 230400, serial bit rate. Bit period DIV = CLK_FREQ/BAUD_RATE (integer floor), must be ≥ 8.
- KBD_DEV, 6'o03, keyboard IOT device code.
- PRT_DEV, 6'o04, printer IOT device code.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- iot_valid  in  1  one-cycle IOT strobe from CPU.
- iot_dev  in  6  IOT device field (IR[3:8]).
- iot_op  in  3  IOP bits {IOP4,IOP2,IOP1} (IR[9:11]).
- ac_in  in  8  AC[4:11] for printer loads.
- iot_done  out  1  one-cycle response pulse, exactly 1 cycle after an addressed iot_valid.
- skip  out  1  valid with iot_done: increment PC.
- ac_clear  out  1  valid with iot_done: clear AC before OR.
- ac_or  out  8  valid with iot_done: OR into AC[4:11]; 0 otherwise.
- int_req  out  1  kbd_flag | prt_flag.
- rx_data  in  1  serial in, idle high.
- tx_data  out  1  serial out, idle high.
- rx_frame_err  out  1  sticky framing error; cleared by KCC.

Behaviour:
- Reset: tx_data=1, all other outputs 0, flags clear, buffers 0, both FSMs idle.
- Reset mid-frame aborts the frame; no partial byte is delivered.
- rx_data is 2-flop synchronised before use.
- Receive FSM (IDLE→START→DATA→STOP):
  - IDLE: falling edge starts the frame; wait DIV/2 and re-check.
  - START: line high at the re-check = glitch, return to IDLE.
  - DATA: sample 8 bits LSB first, one every DIV cycles.
  - STOP: sample the stop bit. If high, write kbd_buf and set kbd_flag. If low, set rx_frame_err and discard the byte. Return to IDLE either way.
- Transmit FSM (IDLE→START→DATA→STOP), each bit DIV cycles, LSB first:
  - At STOP end, set prt_flag; then go to IDLE, or start the pending byte next cycle.
- Keyboard IOT (iot_dev==KBD_DEV), ops combine:
  - IOP1 KSF: skip=kbd_flag.
  - IOP2 KCC: ac_clear=1; clear kbd_flag and rx_frame_err.
  - IOP4 KRS: ac_or=kbd_buf.
  - op 6 KRB: KCC+KRS. Returns the buffer as it was before the clear.
- Printer IOT (iot_dev==PRT_DEV):
  - IOP1 TSF: skip=prt_flag.
  - IOP2 TCF: clear prt_flag.
  - IOP4 TPC: transmit ac_in.
  - op 6 TLS: TCF+TPC.
- TPC while the transmitter is busy: ac_in goes to a single pending register, sent right after the current stop bit. A further TPC overwrites pending.
- Unaddressed device codes: no iot_done; all response outputs stay 0.
- Simultaneous events:
  - Receive completion in the same cycle as KCC: the set wins, so kbd_flag stays 1 and the new byte is latched. A KRB in that same cycle returns the old byte.
  - TX stop-bit completion in the same cycle as TCF: the set wins.
- skip, ac_clear and ac_or are registered and zero whenever iot_done=0.

Optional Feature:
- Macro KL8_RX_FIFO_EN.
- Defined: the keyboard buffer becomes a 4-entry FIFO.
  - kbd_flag = not empty.
  - KRS reads the head; KCC pops.
  - Push and pop in the same cycle both take effect.
  - A byte arriving when full is dropped and sets rx_frame_err.
- Undefined: single buffer. A new byte overwrites kbd_buf even if kbd_flag is already set (overrun silent).

Decomposition:
- Package kl8_pkg holds:
  - IOP bit constants: IOP1=3'b001, IOP2=3'b010, IOP4=3'b100.
  - The shared 4-state serial FSM enum and the DIV function.
- One sub-module, kl8_tx_shifter: transmit FSM, pending register, done pulse.
- Receive logic and IOT decode stay in kl8_tty.

Test Plan:
- Reset: hold rst=0 mid-TX → tx_data=1, int_req=0. Release, then TSF → iot_done=1, skip=0.
- Serial 0x41 on rx_data at DIV spacing → kbd_flag=1, int_req=1. KSF → skip=1. KRB → ac_clear=1, ac_or=0x41, then kbd_flag=0.
- TLS with ac_in=0x5A → tx_data shows start, bits 0,1,0,1,1,0,1,0, stop over 10·DIV cycles. prt_flag sets on the cycle after stop ends; TSF → skip=1.
- TLS 0x31 then TPC 0x32 while busy → two back-to-back frames, no idle gap, order 0x31,0x32.
- Stop bit held low on 0x7F → rx_frame_err=1, kbd_flag stays 0. KCC clears rx_frame_err.
- With KL8_RX_FIFO_EN: send 0x01..0x05 → KRB sequence returns 0x01..0x04, rx_frame_err=1. Without the macro, a KRS after the same stimulus returns 0x05.
